conv_window_mac: RTL

//  Consumes the 4x4 byte window produced by the 4x16 line buffer and sweeps it across.

---
 rtl/conv_window_mac_if.sv | 39 +++
 rtl/conv_window_mac.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_mac_if.sv
// conv_window_mac_if
//   Bundles the control, data and result handshake of conv_window_mac.
//   The slave modport is the MAC's view; the master modport is the view of
//   whatever starts sweeps, supplies window bytes and drains results.
//
//   start      begin a sweep (sampled only while the MAC is idle)
//   filter     4x4 unsigned byte filter, byte i = bits [127-8i -: 8]
//   window     4x4 unsigned byte window for the current idx (combinational)
//   idx        window index presented to the line buffer
//   busy       sweep in progress
//   out_valid  result/out_idx valid
//   out_ready  downstream accepts the result
//   result     dot product of window and filter
//   out_idx    window index the result belongs to
//   done       one-cycle pulse after the last result is accepted
interface conv_window_mac_if #(
    parameter int ACC_W = 20
);
    logic             start;
    logic [127:0]     filter;
    logic [127:0]     window;
    logic [3:0]       idx;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] result;
    logic [3:0]       out_idx;
    logic             done;

    modport master (
        output start, filter, window, out_ready,
        input  idx, busy, out_valid, result, out_idx, done
    );

    modport slave (
        input  start, filter, window, out_ready,
        output idx, busy, out_valid, result, out_idx, done
    );
endinterface

// File: rtl/conv_window_mac.sv
// conv_window_mac
//   Sweeps a 4x4 byte window across the 4x16 line buffer by driving the
//   buffer column index, multiplies every window by a filter latched at the
//   start of the sweep and emits one dot product per window position.
//   Two pipeline stages: 16 registered products, then a registered adder-tree
//   sum. The output is valid/ready with full backpressure: while a result is
//   waiting (out_valid & ~out_ready) the index and both stages hold.
//
//   Ports
//     clk   clock
//     rst   asynchronous, active-high reset
//     bus   conv_window_mac_if.slave: start, filter, window, idx, busy,
//           out_valid, out_ready, result, out_idx, done
//
//   Parameters
//     START_IDX  first window index (rightmost column of the first window)
//     END_IDX    last window index
//     ACC_W      result width; 16 * 255 * 255 fits in 20 bits
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   IDLE   | waiting for start; filter and idx reloaded when start is seen
//   RUN    | one window captured into stage 1 per non-stalled cycle
//   DRAIN  | last window captured; wait for stage 1 to empty and the final
//          | result to be accepted
//   DONE   | done pulse for one cycle, then back to IDLE
module conv_window_mac #(
    parameter logic [3:0] START_IDX = 4'd3,
    parameter logic [3:0] END_IDX   = 4'd15,
    parameter int         ACC_W     = 20
) (
    input  logic               clk,
    input  logic               rst,
    conv_window_mac_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [127:0]     filter_q;
    logic [3:0]       idx_q;

    logic [7:0]       win_byte  [16];
    logic [7:0]       filt_byte [16];

    logic [15:0]      prod_q [16];
    logic             s1_valid;
    logic [3:0]       s1_tag;

    logic [16:0]      sum_l1 [8];
    logic [17:0]      sum_l2 [4];
    logic [18:0]      sum_l3 [2];
    logic [19:0]      sum_l4;
    logic [ACC_W-1:0] sum_tree;

    logic [ACC_W-1:0] result_q;
    logic [3:0]       out_idx_q;
    logic             out_valid_q;

    logic             stall;
    logic             start_accept;
    logic             s1_capture;

    // A held result freezes the whole pipe, including the index the buffer sees.
    assign stall = out_valid_q & ~bus.out_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        start_accept = 1'b0;
        s1_capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    start_accept = 1'b1;
                    state_nxt    = S_RUN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    s1_capture = 1'b1;
                    if (idx_q == END_IDX) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Final result leaves on the same edge that moves us to DONE,
                // so done lands exactly one cycle after the last acceptance.
                if (!s1_valid && (!out_valid_q || bus.out_ready)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Filter latch and window index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filter_q <= '0;
            idx_q    <= START_IDX;
        end else begin
            if (start_accept) begin
                filter_q <= bus.filter;
                idx_q    <= START_IDX;
            end else if (s1_capture && (idx_q != END_IDX)) begin
                idx_q <= idx_q + 4'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            win_byte[i]  = bus.window[127-8*i -: 8];
            filt_byte[i] = filter_q[127-8*i -: 8];
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: products
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            for (int i = 0; i < 16; i++) begin
                prod_q[i] <= '0;
            end
        end else if (!stall) begin
            // Outside RUN this inserts an empty slot, which drains the pipe.
            s1_valid <= s1_capture;
            if (s1_capture) begin
                s1_tag <= idx_q;
                for (int i = 0; i < 16; i++) begin
                    prod_q[i] <= 16'(win_byte[i]) * 16'(filt_byte[i]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Adder tree, widened one bit per level so nothing can overflow
    // ------------------------------------------------------------------
    always_comb begin
        for (int j = 0; j < 8; j++) begin
            sum_l1[j] = 17'(prod_q[2*j]) + 17'(prod_q[2*j+1]);
        end
        for (int j = 0; j < 4; j++) begin
            sum_l2[j] = 18'(sum_l1[2*j]) + 18'(sum_l1[2*j+1]);
        end
        for (int j = 0; j < 2; j++) begin
            sum_l3[j] = 19'(sum_l2[2*j]) + 19'(sum_l2[2*j+1]);
        end
        sum_l4   = 20'(sum_l3[0]) + 20'(sum_l3[1]);
        sum_tree = ACC_W'(sum_l4);
    end

    // ------------------------------------------------------------------
    // Stage 2: result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            out_idx_q   <= '0;
        end else if (!stall) begin
            // When the held result is taken and stage 1 is empty, out_valid
            // falls here because the empty slot moves forward.
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                result_q  <= sum_tree;
                out_idx_q <= s1_tag;
            end
        end
    end

    assign bus.idx       = idx_q;
    assign bus.busy      = (state == S_RUN) || (state == S_DRAIN);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.done      = (state == S_DONE);

endmodule
